byte_serial_tx: RTL
===================

// Module: byte_serial_tx
// PURPOSE
//  Transmit end of the 8-bit register datapath: accepts one byte via valid/ready handshake and
//  shifts it out on a single serial line as a framed word (start bit, DATA_W data bits, stop bit).
//  Sits downstream of the 8-bit holding registers; pairs with a serial receiver at the far end.
// PARAMETERS
//  DATA_W        8   data bits per frame
//  CLKS_PER_BIT  4   clk cycles each serial bit is held (>=1)
//  LSB_FIRST     1   1: bit 0 sent first; 0: bit DATA_W-1 sent first
// PORTS
//  clk        in   1       clock, all state on posedge
//  reset      in   1       asynchronous, active-low reset
//  din        in   DATA_W  byte to transmit, sampled on accept
//  din_valid  in   1       din holds a byte to send
//  din_ready  out  1       block can accept a byte this cycle
//  txd        out  1       serial line, idle high
//  busy       out  1       frame in progress (START..STOP)
//  done       out  1       one-cycle pulse at end of stop bit
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, txd=1, din_ready=1, busy=0, done=0, shift reg=0,
//    counters=0. Reset mid-frame aborts the frame at once; line returns to 1, no done pulse.
//  - Accept: din_valid & din_ready at posedge -> din latched into shift reg, state IDLE->START.
//    din_ready=1 only in IDLE; din_valid while busy is ignored, no data captured.
//  - FSM: IDLE -> START (txd=0, CLKS_PER_BIT cycles) -> DATA (DATA_W bits, each CLKS_PER_BIT
//    cycles) -> STOP (txd=1, CLKS_PER_BIT cycles) -> IDLE.
//  - txd is registered: start bit appears on txd the cycle after accept. Frame length exactly
//    (DATA_W+2)*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
//  - DATA: bit order per LSB_FIRST; shift reg shifts one position at end of each bit period;
//    bit index counter 0..DATA_W-1, no wrap past DATA_W-1 (leaves to STOP).
//  - Bit timer counts 0..CLKS_PER_BIT-1, wraps to 0 with a tick; tick advances bit/state.
//    CLKS_PER_BIT=1: tick every cycle, no timer state needed.
//  - done=1 in the last cycle of STOP only; next cycle state=IDLE, din_ready=1.
//    Back-to-back: a byte offered during done is NOT accepted; earliest accept is the cycle
//    after done, giving min one idle-high cycle between frames.
//  - busy=1 exactly while state != IDLE.
//  - Counter widths: $clog2(CLKS_PER_BIT) (min 1) and $clog2(DATA_W) (min 1); no overflow.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3),
//    line idle level constant (1'b1), width helper for counters.
//  - One sub-module: bit_timer (parameter CLKS_PER_BIT; in clk, reset, run; out tick).
//    run=0 clears count to 0. FSM, shift reg and bit counter stay in the top module.
// TESTING
//  1. Reset held low 3 cycles with din_valid=1 -> txd=1, din_ready=1, busy=0, done=0 throughout.
//  2. Send 8'hA5, CLKS_PER_BIT=4, LSB_FIRST=1 -> txd = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles;
//     busy high 40 cycles; done pulse in cycle 40; din_ready back high cycle 41.
//  3. Back-to-back 8'h00 then 8'hFF with din_valid held high -> second frame starts exactly
//     2 cycles after first done (1 accept cycle + registered txd); both frames bit-exact.
//  4. Change din and pulse din_valid mid-frame -> ignored; current frame unchanged, no extra frame.
//  5. Assert reset during DATA bit 3 of 8'h3C -> txd=1 immediately (async), busy=0, no done;
//     after release a new byte 8'h81 transmits correctly from START.
//  6. CLKS_PER_BIT=1, LSB_FIRST=0, send 8'h80 -> txd = 0,1,0,0,0,0,0,0,0,1 one cycle each;
//     done on 10th frame cycle.

Source files
------------

// File: rtl/byte_serial_tx_pkg.sv
// byte_serial_tx_pkg
// Shared definitions for the byte-serial transmitter slice.
//   - FSM state encoding for the frame sequencer
//   - idle level of the serial line
//   - counter width helper (never returns less than one bit)
package byte_serial_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic LINE_IDLE = 1'b1;

  // Width needed to count 0..n-1. A single-value counter still gets one bit
  // so that no zero-width vector is ever declared.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/byte_serial_tx_bit_timer.sv
// bit_timer
// Divides the clock into serial bit periods of CLKS_PER_BIT cycles.
// Ports:
//   clk   in  clock, posedge
//   reset in  asynchronous, active-low
//   run   in  1: count; 0: hold the count at zero
//   tick  out high in the last cycle of each bit period while running
module bit_timer
  import byte_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  generate
    if (CLKS_PER_BIT == 1) begin : g_noCount
      // Every running cycle is a whole bit period, so no count is kept.
      assign tick = run;
    end else begin : g_count
      localparam int TW = cntWidth(CLKS_PER_BIT);
      localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

      logic [TW-1:0] count_q;
      logic [TW-1:0] count_d;

      // The count restarts at zero whenever the timer is stopped or a period
      // completes, so the first running cycle is always the start of a bit.
      always_comb begin
        count_d = count_q + 1'b1;
        if (!run || (count_q == LAST)) begin
          count_d = '0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign tick = run && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/byte_serial_tx.sv
// byte_serial_tx
// Accepts one byte over a valid/ready handshake and shifts it out on a single
// serial line as start bit (0), DATA_W data bits, stop bit (1), each held for
// CLKS_PER_BIT clocks.
// Ports:
//   clk        in   clock, posedge
//   reset      in   asynchronous, active-low
//   din        in   byte to send, captured on accept
//   din_valid  in   din holds a byte to send
//   din_ready  out  high only while idle
//   txd        out  registered serial line, idle high
//   busy       out  a frame is in progress
//   done       out  one-cycle pulse in the last stop-bit cycle
module byte_serial_tx
  import byte_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int BW = cntWidth(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bitCnt_q, bitCnt_d;
  logic              txd_q, txd_d;
  logic              tick;
  logic [DATA_W-1:0] shifted;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitTimer (
    .clk  (clk),
    .reset(reset),
    .run  (state_q != ST_IDLE),
    .tick (tick)
  );

  // The bit to be sent next always sits at the outgoing end of the shift reg.
  function automatic logic headBit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  assign shifted = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);

  // Frame sequencer. txd_d is the line level for the coming cycle, so each
  // transition loads the level of the bit that begins there; this keeps txd
  // registered while staying aligned with the state.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    txd_d    = txd_q;
    case (state_q)
      ST_IDLE: begin
        txd_d = LINE_IDLE;
        if (din_valid) begin
          state_d  = ST_START;
          shift_d  = din;
          bitCnt_d = '0;
          txd_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = headBit(shift_q);
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shifted;
          if (bitCnt_q == LAST_BIT) begin
            state_d  = ST_STOP;
            bitCnt_d = '0;
            txd_d    = LINE_IDLE;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            txd_d    = headBit(shifted);
          end
        end
      end
      ST_STOP: begin
        txd_d = LINE_IDLE;
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = LINE_IDLE;
      end
    endcase
  end

  // Reset aborts any frame immediately and forces the line back to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      txd_q    <= LINE_IDLE;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      txd_q    <= txd_d;
    end
  end

  assign din_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_STOP) && tick;
  assign txd       = txd_q;

endmodule
